sequence_010_generator: RTL and testbench
=========================================

Name: sequence_010_generator

Overview:
- Serial stimulus source for the 010 sequence detector. It is the transmitting end of the same one-bit-per-clock serial interface.
- Loads a parallel pattern and shifts it out MSB-first on `x`, one bit per clock.
- While shifting, it keeps a reference count of overlapping "010" occurrences in the emitted stream, so a bench or system can compare that count against the detector's count.
- Sits upstream of the detector, driven by a controller or testbench through a start/busy/done handshake.

Parameters:
- WIDTH, 16: maximum frame length in bits; width of `pattern`.
- LEN_W, 5: width of `len`; must hold the value WIDTH.
- CNT_W, 10: width of `exp_count`; matches the detector's 10-bit count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request to send a frame; sampled only in IDLE
- pattern  input  WIDTH  frame data; bits pattern[len-1:0] are sent
- len  input  LEN_W  frame length in bits; values above WIDTH are clamped to WIDTH
- loop  input  1  continuous-repeat request; only honoured with SEQ_GEN_LOOP_EN
- x  output  1  serial data bit toward the detector
- valid  output  1  high while `x` carries a frame bit
- busy  output  1  high from the cycle after an accepted start until the done pulse
- done  output  1  one-cycle pulse after the last bit of a frame
- exp_count  output  CNT_W  number of overlapping 010 occurrences emitted since the last accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: x=0, valid=0, busy=0, done=0, exp_count=0.
  - Internal state: FSM goes to IDLE, shift register and 2-bit history cleared.
  - Effect is immediate, including mid-frame. The partial frame is abandoned, with no done pulse.
- FSM states: IDLE, SHIFT, FIN.
- IDLE:
  - x=0, valid=0.
  - On start=1 with effective len≥1:
    - latch pattern and len;
    - clear exp_count and the history;
    - go to SHIFT.
  - On start=1 with len=0: no bits are sent. Go to FIN, so done pulses on the next cycle and exp_count is cleared to 0.
- SHIFT:
  - Bit k is driven in cycle k after the start edge, k=1..len. Bit 1 = pattern[len-1], bit len = pattern[0].
  - valid=1 and busy=1 in every SHIFT cycle.
  - After the final bit, go to FIN.
- FIN:
  - done=1, busy=0, valid=0, x=0, for exactly one cycle.
  - Then return to IDLE.
  - start is not sampled in FIN.
- Handshake: start is ignored while busy=1 or in FIN. It is not queued. Earliest restart is the cycle after the done pulse.
- 010 counting:
  - Overlapping: stream 01010 counts 2.
  - A match is counted when the current bit is 0 and the previous two frame bits are 0,1. Only bits of the current frame count; the history is reset on every accepted start.
  - exp_count updates at the clock edge that ends the cycle in which the completing 0 is driven, so its final value is visible in the FIN cycle.
  - exp_count saturates at 2^CNT_W−1. It holds its value through IDLE until the next accepted start.
- `pattern` and `len` may change freely once latched; the frame uses the latched values.

Optional Feature:
- Macro: SEQ_GEN_LOOP_EN.
- Defined:
  - If loop=1 when the last bit is driven, go directly to SHIFT and resend the latched frame with no gap cycle.
  - valid and busy stay high, and no done pulse is issued.
  - History and exp_count carry across the frame boundary, so a 010 spanning two frames is counted.
  - If loop=0 at the last bit, the block finishes normally through FIN.
- Not defined: loop is ignored and every frame ends through FIN with a done pulse.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-stream → x=0, valid=0, busy=0, done=0, exp_count=0 immediately. After rst=1, the block idles with x=0.
- Overlap: start, len=5, pattern=16'h000A →
  - x=0,1,0,1,0 in cycles 1–5 with valid=1;
  - done=1 in cycle 6;
  - exp_count=2 in cycle 6.
- Count accuracy: len=9, pattern=9'b001100111 → x=0,0,1,1,0,0,1,1,1 and exp_count=0. Then len=16, pattern=16'h4924 → exp_count=5.
- Ignored start: start pulsed in cycles 2 and 6 of a len=8 frame → neither pulse is accepted, done=1 exactly once, 9 cycles after the accepted start. len=0 with start → done pulse next cycle, valid never high, exp_count=0.
- Saturation (CNT_W=2, SEQ_GEN_LOOP_EN, loop=1, len=3, pattern=3'b010) → exp_count reaches 3 and holds at 3. Setting loop=0 ends the stream with a single done pulse.

Source files
------------

// File: rtl/sequence_010_generator.sv
// Serial frame source for the 010 detector: shifts a latched pattern out MSB-first
// and keeps a saturating count of overlapping 010s. SEQ_GEN_LOOP_EN enables gapless frame repeat.
module sequence_010_generator #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned LEN_W = 5,
   parameter int unsigned CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic             loop,
   output logic             x,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] exp_count
);

   typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0]   pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [1:0]         hist_q, hist_d;
   logic [1:0]         hvld_q, hvld_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [LEN_W-1:0]   eff_len;
   logic [WIDTH-1:0]   aligned;
   logic               cur_bit;
   logic               loop_req;

`ifdef SEQ_GEN_LOOP_EN
   assign loop_req = loop;
`else
   assign loop_req = loop & 1'b0;
`endif

   assign eff_len = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
   // Left-align the frame so the first bit to send always sits in the MSB.
   assign aligned = pattern << (LEN_W'(WIDTH) - eff_len);
   assign cur_bit = sr_q[WIDTH-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         hist_q  <= '0;
         hvld_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         hist_q  <= hist_d;
         hvld_q  <= hvld_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      pat_d   = pat_q;
      len_d   = len_q;
      rem_d   = rem_q;
      hist_d  = hist_q;
      hvld_d  = hvld_q;
      cnt_d   = cnt_q;
      x       = 1'b0;
      valid   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d  = '0;
               hist_d = '0;
               hvld_d = '0;
               if (eff_len == '0) begin
                  state_d = FIN;
               end else begin
                  pat_d   = aligned;
                  sr_d    = aligned;
                  len_d   = eff_len;
                  rem_d   = eff_len;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            x     = cur_bit;
            valid = 1'b1;
            busy  = 1'b1;
            // hvld_q marks which history slots hold real frame bits, so no match spans a start.
            if (hvld_q == 2'b11 && hist_q == 2'b01 && !cur_bit && cnt_q != '1)
               cnt_d = cnt_q + 1'b1;
            hist_d = {hist_q[0], cur_bit};
            hvld_d = {hvld_q[0], 1'b1};
            sr_d   = sr_q << 1;
            rem_d  = rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
               if (loop_req) begin
                  sr_d  = pat_q;
                  rem_d = len_q;
               end else begin
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign exp_count = cnt_q;

endmodule

// File: tb/tb_sequence_010_generator.sv
// Directed bench for sequence_010_generator: default instance plus a CNT_W=2 instance for saturation.
module tb_sequence_010_generator;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] pattern;
   logic [4:0]  len;
   logic        loop;

   logic        x, valid, busy, done;
   logic [9:0]  exp_count;
   logic        s_x, s_valid, s_busy, s_done;
   logic [1:0]  s_exp_count;

   int unsigned total = 0;
   int unsigned fails = 0;

   always #5 clk = ~clk;

   sequence_010_generator #(.WIDTH(16), .LEN_W(5), .CNT_W(10)) u_dut (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .loop(loop),
      .x(x), .valid(valid), .busy(busy), .done(done), .exp_count(exp_count)
   );

   sequence_010_generator #(.WIDTH(16), .LEN_W(5), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .loop(loop),
      .x(s_x), .valid(s_valid), .busy(s_busy), .done(s_done), .exp_count(s_exp_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic frame_start(input logic [15:0] pat, input logic [4:0] l);
      pattern = pat;
      len     = l;
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   initial begin
      logic [4:0] ov_bits;
      logic [8:0] ca_bits;
      rst = 1'b0; start = 1'b0; pattern = '0; len = '0; loop = 1'b0;
      repeat (2) step();
      chk("reset_x", x, 0);
      chk("reset_valid", valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_cnt", exp_count, 0);
      rst = 1'b1;
      step();
      chk("idle_x", x, 0);

      // overlap: 01010 -> 2
      ov_bits = 5'b01010;
      frame_start(16'h000A, 5'd5);
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("ovl_x%0d", k), x, ov_bits[5-k]);
         chk($sformatf("ovl_valid%0d", k), valid, 1);
         chk($sformatf("ovl_busy%0d", k), busy, 1);
         step();
      end
      chk("ovl_done", done, 1);
      chk("ovl_cnt", exp_count, 2);
      chk("ovl_fin_busy", busy, 0);
      chk("ovl_fin_valid", valid, 0);
      step();
      chk("ovl_idle_done", done, 0);
      chk("ovl_hold_cnt", exp_count, 2);

      // count accuracy: no 010 in 001100111
      ca_bits = 9'b001100111;
      frame_start(16'h0067, 5'd9);
      for (int k = 1; k <= 9; k++) begin
         chk($sformatf("ca_x%0d", k), x, ca_bits[9-k]);
         step();
      end
      chk("ca_done", done, 1);
      chk("ca_cnt", exp_count, 0);
      step();

      // 4924 -> 5, pattern changed after latch; CNT_W=2 instance saturates at 3
      frame_start(16'h4924, 5'd16);
      pattern = 16'h0000;
      len     = 5'd2;
      repeat (16) step();
      chk("c16_done", done, 1);
      chk("c16_cnt", exp_count, 5);
      chk("sat_cnt", s_exp_count, 3);
      chk("sat_done", s_done, 1);
      step();
      chk("c16_hold", exp_count, 5);
      chk("sat_hold", s_exp_count, 3);

      // start pulses in cycles 2 and 6 are ignored; done only in cycle 9
      frame_start(16'h00A5, 5'd8);
      for (int k = 1; k <= 10; k++) begin
         start = (k == 2 || k == 6);
         chk($sformatf("ign_done%0d", k), done, (k == 9));
         step();
      end
      start = 1'b0;
      chk("ign_noqueue_busy", busy, 0);
      chk("ign_noqueue_valid", valid, 0);
      chk("ign_cnt", exp_count, 2);

      // len = 0: immediate done, nothing sent, count cleared
      frame_start(16'hFFFF, 5'd0);
      chk("len0_done", done, 1);
      chk("len0_valid", valid, 0);
      chk("len0_cnt", exp_count, 0);
      step();
      chk("len0_done2", done, 0);
      chk("len0_valid2", valid, 0);

      // len above WIDTH clamps to 16 bits
      frame_start(16'h4924, 5'd31);
      for (int k = 1; k <= 16; k++) begin
         chk($sformatf("clamp_valid%0d", k), valid, 1);
         step();
      end
      chk("clamp_done", done, 1);
      chk("clamp_cnt", exp_count, 5);
      step();

      // asynchronous reset mid-frame
      frame_start(16'h4924, 5'd16);
      repeat (3) step();
      chk("pre_rst_cnt", exp_count, 1);
      rst = 1'b0;
      #1;
      chk("arst_x", x, 0);
      chk("arst_valid", valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_cnt", exp_count, 0);
      repeat (2) step();
      chk("arst_hold_done", done, 0);
      rst = 1'b1;
      step();
      chk("post_rst_x", x, 0);
      chk("post_rst_valid", valid, 0);
      chk("post_rst_busy", busy, 0);

`ifdef SEQ_GEN_LOOP_EN
      // gapless repeat of 010: one match per frame, sat instance pinned at 3
      loop = 1'b1;
      frame_start(16'h0002, 5'd3);
      for (int k = 1; k <= 12; k++) begin
         chk($sformatf("loop_valid%0d", k), valid, 1);
         chk($sformatf("loop_done%0d", k), done, 0);
         step();
      end
      chk("loop_cnt4", exp_count, 4);
      chk("loop_sat", s_exp_count, 3);
      loop = 1'b0;
      repeat (3) step();
      chk("loop_end_done", done, 1);
      chk("loop_end_cnt", exp_count, 5);
      chk("loop_end_sat", s_exp_count, 3);
      step();
      chk("loop_single_done", done, 0);
`endif

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
